// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_pkg
// Purpose  : Shared definitions for the MIPS control pipeline: bundle
//            widths, bit positions inside each bundle, forwarding-select
//            encodings and the all-zero bubble bundle.
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pipe_pkg;

    localparam int WB_W  = 2;
    localparam int M_W   = 3;
    localparam int EXE_W = 6;

    // wb bundle
    localparam int WB_REG_WRITE   = 0;
    localparam int WB_MEM_TO_REG  = 1;
    // m bundle
    localparam int M_BRANCH       = 0;
    localparam int M_MEM_READ     = 1;
    localparam int M_MEM_WRITE    = 2;
    // exe bundle
    localparam int EXE_REG_DST    = 0;
    localparam int EXE_ALU_SRC    = 1;
    localparam int EXE_ALU_OP_LSB = 2;

    // EX operand source selects
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [M_W-1:0]   m;
        logic [EXE_W-1:0] exe;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // The younger result (EX/MEM) takes precedence over MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic exmem_hit,
                                           input logic memwb_hit);
        if (exmem_hit) return FWD_EXMEM;
        if (memwb_hit) return FWD_MEMWB;
        return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Purpose  : Combinational hazard logic: load-use / dependency stall,
//            branch-taken flush and EX operand forwarding selects.
// Ports    : id_valid, id_rs, id_rt          - instruction currently in ID
//            ex_m, ex_wb, ex_dst, ex_rs, ex_rt, ex_branch_taken - EX stage
//            mem_wb, mem_dst                 - MEM stage
//            wb_wb, wb_dst                   - WB stage
//            stall, flush_if_id, fwd_a, fwd_b - hazard outputs
// Config   : CTRL_PIPE_FWD_EN defined   -> forwarding, load-use stall only
//            CTRL_PIPE_FWD_EN undefined -> no forwarding, stall on any
//                                          pending EX/MEM producer
// Revision : 1.0  initial release
// ============================================================================
module hazard_fwd_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs,
    input  logic [RAW-1:0]  id_rt,
    input  logic [M_W-1:0]  ex_m,
    input  logic [WB_W-1:0] ex_wb,
    input  logic [RAW-1:0]  ex_dst,
    input  logic [RAW-1:0]  ex_rs,
    input  logic [RAW-1:0]  ex_rt,
    input  logic            ex_branch_taken,
    input  logic [WB_W-1:0] mem_wb,
    input  logic [RAW-1:0]  mem_dst,
    input  logic [WB_W-1:0] wb_wb,
    input  logic [RAW-1:0]  wb_dst,
    output logic            stall,
    output logic            flush_if_id,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    logic w_flush;
    logic w_stall_raw;
    logic w_unused;

    function automatic logic id_uses(input logic [RAW-1:0] dst,
                                     input logic [RAW-1:0] rs,
                                     input logic [RAW-1:0] rt);
        return (dst != '0) && ((dst == rs) || (dst == rt));
    endfunction

    // A taken branch only counts when the EX instruction really is a branch.
    assign w_flush = ex_m[M_BRANCH] & ex_branch_taken;

`ifdef CTRL_PIPE_FWD_EN
    logic w_exmem_a, w_exmem_b, w_memwb_a, w_memwb_b;

    assign w_stall_raw = id_valid & ex_m[M_MEM_READ] & id_uses(ex_dst, id_rs, id_rt);

    assign w_exmem_a = mem_wb[WB_REG_WRITE] & (mem_dst != '0) & (mem_dst == ex_rs);
    assign w_exmem_b = mem_wb[WB_REG_WRITE] & (mem_dst != '0) & (mem_dst == ex_rt);
    assign w_memwb_a = wb_wb[WB_REG_WRITE]  & (wb_dst  != '0) & (wb_dst  == ex_rs);
    assign w_memwb_b = wb_wb[WB_REG_WRITE]  & (wb_dst  != '0) & (wb_dst  == ex_rt);

    assign fwd_a = fwd_sel(w_exmem_a, w_memwb_a);
    assign fwd_b = fwd_sel(w_exmem_b, w_memwb_b);

    assign w_unused = ^{ex_wb, ex_m[M_MEM_WRITE], mem_wb[WB_MEM_TO_REG],
                        wb_wb[WB_MEM_TO_REG]};
`else
    // Without forwarding the consumer waits until the producer reaches WB;
    // the write-first register file covers the WB case.
    assign w_stall_raw = id_valid &
        ((ex_wb[WB_REG_WRITE]  & id_uses(ex_dst,  id_rs, id_rt)) |
         (mem_wb[WB_REG_WRITE] & id_uses(mem_dst, id_rs, id_rt)));

    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;

    assign w_unused = ^{ex_rs, ex_rt, wb_wb, wb_dst, ex_wb[WB_MEM_TO_REG],
                        ex_m[M_MEM_WRITE:M_MEM_READ], mem_wb[WB_MEM_TO_REG]};
`endif

    // The instruction being stalled is on the wrong path when a branch
    // resolves taken, so the flush wins.
    assign stall       = w_stall_raw & ~w_flush;
    assign flush_if_id = w_flush;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : Carries decoded control bundles through the ID/EX, EX/MEM and
//            MEM/WB registers and hosts the hazard / forwarding unit.
// Ports    : clk, reset (async, active-high)
//            id_valid, id_wb, id_m, id_exe, id_rs, id_rt, id_rd - ID inputs
//            ex_branch_taken                - branch result of EX instr
//            stall, flush_if_id, fwd_a, fwd_b - hazard outputs
//            ex_*, mem_*, wb_*              - per-stage control and dst
// Config   : CTRL_PIPE_FWD_EN enables operand forwarding (see
//            hazard_fwd_unit).
// Revision : 1.0  initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [WB_W-1:0]  id_wb,
    input  logic [M_W-1:0]   id_m,
    input  logic [EXE_W-1:0] id_exe,
    input  logic [RAW-1:0]   id_rs,
    input  logic [RAW-1:0]   id_rt,
    input  logic [RAW-1:0]   id_rd,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush_if_id,
    output logic [EXE_W-1:0] ex_exe,
    output logic [M_W-1:0]   ex_m,
    output logic [WB_W-1:0]  ex_wb,
    output logic [RAW-1:0]   ex_dst,
    output logic [M_W-1:0]   mem_m,
    output logic [WB_W-1:0]  mem_wb,
    output logic [RAW-1:0]   mem_dst,
    output logic [WB_W-1:0]  wb_wb,
    output logic [RAW-1:0]   wb_dst,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    ctrl_bundle_t    r_ex_ctrl;
    logic [RAW-1:0]  r_ex_rs;
    logic [RAW-1:0]  r_ex_rt;
    logic [RAW-1:0]  r_ex_dst;
    logic [M_W-1:0]  r_mem_m;
    logic [WB_W-1:0] r_mem_wb;
    logic [RAW-1:0]  r_mem_dst;
    logic [WB_W-1:0] r_wb_wb;
    logic [RAW-1:0]  r_wb_dst;

    logic            w_load_bubble;
    logic [RAW-1:0]  w_id_dst;

    assign w_id_dst      = id_exe[EXE_REG_DST] ? id_rd : id_rt;
    assign w_load_bubble = ~id_valid | stall | flush_if_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_ctrl <= BUBBLE;
            r_ex_rs   <= '0;
            r_ex_rt   <= '0;
            r_ex_dst  <= '0;
            r_mem_m   <= '0;
            r_mem_wb  <= '0;
            r_mem_dst <= '0;
            r_wb_wb   <= '0;
            r_wb_dst  <= '0;
        end else begin
            if (w_load_bubble) begin
                r_ex_ctrl <= BUBBLE;
                r_ex_rs   <= '0;
                r_ex_rt   <= '0;
                r_ex_dst  <= '0;
            end else begin
                r_ex_ctrl <= '{wb: id_wb, m: id_m, exe: id_exe};
                r_ex_rs   <= id_rs;
                r_ex_rt   <= id_rt;
                r_ex_dst  <= w_id_dst;
            end
            // Later stages never stall: older instructions always drain.
            r_mem_m   <= r_ex_ctrl.m;
            r_mem_wb  <= r_ex_ctrl.wb;
            r_mem_dst <= r_ex_dst;
            r_wb_wb   <= r_mem_wb;
            r_wb_dst  <= r_mem_dst;
        end
    end

    hazard_fwd_unit #(
        .RAW (RAW)
    ) u_hazard_fwd_unit (
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_m            (r_ex_ctrl.m),
        .ex_wb           (r_ex_ctrl.wb),
        .ex_dst          (r_ex_dst),
        .ex_rs           (r_ex_rs),
        .ex_rt           (r_ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_wb          (r_mem_wb),
        .mem_dst         (r_mem_dst),
        .wb_wb           (r_wb_wb),
        .wb_dst          (r_wb_dst),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    assign ex_exe  = r_ex_ctrl.exe;
    assign ex_m    = r_ex_ctrl.m;
    assign ex_wb   = r_ex_ctrl.wb;
    assign ex_dst  = r_ex_dst;
    assign mem_m   = r_mem_m;
    assign mem_wb  = r_mem_wb;
    assign mem_dst = r_mem_dst;
    assign wb_wb   = r_wb_wb;
    assign wb_dst  = r_wb_dst;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Self-checking bench for ctrl_pipe. Directed scenarios followed
//            by random traffic, all compared against an instruction-level
//            model of the three in-flight stages.
// Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe;

    typedef struct {
        logic [1:0] wb;
        logic [2:0] m;
        logic [5:0] exe;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [1:0] id_wb;
    logic [2:0] id_m;
    logic [5:0] id_exe;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_branch_taken;
    logic       stall, flush_if_id;
    logic [5:0] ex_exe;
    logic [2:0] ex_m, mem_m;
    logic [1:0] ex_wb, mem_wb, wb_wb;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic [1:0] fwd_a, fwd_b;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the instruction occupying each stage (all-zero record = bubble).
    rec_t m_ex, m_mem, m_wb;
    rec_t zero_rec;

    ctrl_pipe #(.RAW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_wb(id_wb),
        .id_m(id_m), .id_exe(id_exe), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .stall(stall),
        .flush_if_id(flush_if_id), .ex_exe(ex_exe), .ex_m(ex_m),
        .ex_wb(ex_wb), .ex_dst(ex_dst), .mem_m(mem_m), .mem_wb(mem_wb),
        .mem_dst(mem_dst), .wb_wb(wb_wb), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t id_rec();
        rec_t r;
        r.wb  = id_wb;
        r.m   = id_m;
        r.exe = id_exe;
        r.rs  = id_rs;
        r.rt  = id_rt;
        r.dst = id_exe[0] ? id_rd : id_rt;
        return r;
    endfunction

    // True when the ID instruction reads a nonzero register written by p.
    function automatic bit reads_from(input rec_t p);
        return (p.dst != 0) && (p.dst == id_rs || p.dst == id_rt);
    endfunction

    function automatic bit exp_flush();
        return m_ex.m[0] && ex_branch_taken;
    endfunction

    function automatic bit exp_stall();
        bit hz;
`ifdef CTRL_PIPE_FWD_EN
        hz = id_valid && m_ex.m[1] && reads_from(m_ex);
`else
        hz = id_valid && ((m_ex.wb[0] && reads_from(m_ex)) ||
                          (m_mem.wb[0] && reads_from(m_mem)));
`endif
        return hz && !exp_flush();
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
`ifdef CTRL_PIPE_FWD_EN
        if (m_mem.wb[0] && m_mem.dst != 0 && m_mem.dst == src) return 2'b10;
        if (m_wb.wb[0]  && m_wb.dst  != 0 && m_wb.dst  == src) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic check_all();
        chk("stall",   stall,       exp_stall());
        chk("flush",   flush_if_id, exp_flush());
        chk("ex_exe",  ex_exe,      m_ex.exe);
        chk("ex_m",    ex_m,        m_ex.m);
        chk("ex_wb",   ex_wb,       m_ex.wb);
        chk("ex_dst",  ex_dst,      m_ex.dst);
        chk("mem_m",   mem_m,       m_mem.m);
        chk("mem_wb",  mem_wb,      m_mem.wb);
        chk("mem_dst", mem_dst,     m_mem.dst);
        chk("wb_wb",   wb_wb,       m_wb.wb);
        chk("wb_dst",  wb_dst,      m_wb.dst);
        chk("fwd_a",   fwd_a,       exp_fwd(m_ex.rs));
        chk("fwd_b",   fwd_b,       exp_fwd(m_ex.rt));
    endtask

    // Drive ID, let it settle, compare everything.
    task automatic cyc(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [5:0] exe, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic br);
        id_valid = v; id_wb = wb; id_m = m; id_exe = exe;
        id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = br;
        #2;
        check_all();
    endtask

    // Clock edge; the model moves every instruction down one stage.
    task automatic tick();
        rec_t nxt;
        bit   bub;
        bub = !id_valid || exp_stall() || exp_flush();
        nxt = bub ? zero_rec : id_rec();
        @(posedge clk);
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = nxt;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        zero_rec = '{wb: 0, m: 0, exe: 0, rs: 0, rt: 0, dst: 0};
        m_ex = zero_rec; m_mem = zero_rec; m_wb = zero_rec;
        reset = 1'b1;
        id_valid = 0; id_wb = 0; id_m = 0; id_exe = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; ex_branch_taken = 0;
        #2;
        check_all();
        #1 reset = 1'b0;
        tick();

        // Plain propagation of an R-type writing r3
        cyc(1, 2'b01, 3'b000, 6'b001001, 5'd1, 5'd2, 5'd3, 0);
        chk("prop_stall", stall, 0);
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("prop_ex_dst", ex_dst, 3);
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("prop_mem_dst", mem_dst, 3);
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("prop_wb_wb", wb_wb, 2'b01);
        chk("prop_wb_dst", wb_dst, 3);
        tick();

`ifdef CTRL_PIPE_FWD_EN
        // Load-use: lw r5 then add rs=5
        cyc(1, 2'b11, 3'b010, 6'b000010, 5'd1, 5'd5, 5'd0, 0);
        tick();
        cyc(1, 2'b01, 3'b000, 6'b000001, 5'd5, 5'd6, 5'd7, 0);
        chk("lu_stall_1", stall, 1);
        tick();
        cyc(1, 2'b01, 3'b000, 6'b000001, 5'd5, 5'd6, 5'd7, 0);
        chk("lu_stall_2", stall, 0);
        chk("lu_bubble_exe", ex_exe, 0);
        chk("lu_bubble_dst", ex_dst, 0);
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_a", fwd_a, 2'b01);
        tick();

        // Forward priority: add r4, sub r4, or rs=4
        cyc(1, 2'b01, 3'b000, 6'b001001, 5'd1, 5'd2, 5'd4, 0); tick();
        cyc(1, 2'b01, 3'b000, 6'b010001, 5'd1, 5'd2, 5'd4, 0); tick();
        cyc(1, 2'b01, 3'b000, 6'b011001, 5'd4, 5'd6, 5'd8, 0); tick();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("prio_fwd_a", fwd_a, 2'b10);
        tick();
`else
        // Without forwarding: add r2 then add rs=2 stalls two cycles
        cyc(1, 2'b01, 3'b000, 6'b001001, 5'd1, 5'd1, 5'd2, 0); tick();
        cyc(1, 2'b01, 3'b000, 6'b001001, 5'd2, 5'd3, 5'd9, 0);
        chk("nf_stall_1", stall, 1);
        tick();
        cyc(1, 2'b01, 3'b000, 6'b001001, 5'd2, 5'd3, 5'd9, 0);
        chk("nf_stall_2", stall, 1);
        chk("nf_fwd_a", fwd_a, 2'b00);
        tick();
        cyc(1, 2'b01, 3'b000, 6'b001001, 5'd2, 5'd3, 5'd9, 0);
        chk("nf_stall_3", stall, 0);
        tick();
`endif
        idle(); idle(); idle();

        // Branch taken while a load-use/dependency condition is also present
        cyc(1, 2'b01, 3'b011, 6'b000000, 5'd1, 5'd5, 5'd0, 0); tick();
        cyc(1, 2'b01, 3'b000, 6'b000001, 5'd5, 5'd6, 5'd7, 1);
        chk("br_flush", flush_if_id, 1);
        chk("br_stall", stall, 0);
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_ex_exe", ex_exe, 0);
        chk("br_ex_m", ex_m, 0);
        chk("br_ex_wb", ex_wb, 0);
        tick();
        idle(); idle(); idle();

        // Register 0 is never a hazard
        cyc(1, 2'b01, 3'b000, 6'b000001, 5'd1, 5'd2, 5'd0, 0); tick();
        cyc(1, 2'b01, 3'b000, 6'b000001, 5'd0, 5'd0, 5'd1, 0);
        chk("r0_stall", stall, 0);
        tick();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_fwd_a", fwd_a, 0);
        chk("r0_fwd_b", fwd_b, 0);
        tick();

        // Random traffic; small register range to provoke hazards
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 7) != 0, 2'($urandom), 3'($urandom),
                6'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom));
            tick();
        end

        // Asynchronous reset in the middle of traffic
        cyc(1, 2'b01, 3'b000, 6'b000001, 5'd1, 5'd2, 5'd3, 0); tick();
        cyc(1, 2'b11, 3'b010, 6'b000010, 5'd1, 5'd2, 5'd1, 0); tick();
        id_valid = 0; ex_branch_taken = 0;
        reset = 1'b1;
        #1;
        chk("rst_ex_exe", ex_exe, 0);
        chk("rst_ex_m", ex_m, 0);
        chk("rst_ex_wb", ex_wb, 0);
        chk("rst_ex_dst", ex_dst, 0);
        chk("rst_mem_m", mem_m, 0);
        chk("rst_mem_wb", mem_wb, 0);
        chk("rst_mem_dst", mem_dst, 0);
        chk("rst_wb_wb", wb_wb, 0);
        chk("rst_wb_dst", wb_dst, 0);
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush_if_id, 0);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        m_ex = zero_rec; m_mem = zero_rec; m_wb = zero_rec;
        reset = 1'b0;
        #1;
        tick();

        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
                6'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control bundles (wb, m, exe) produced in ID through the ID/EX, EX/MEM and MEM/WB pipeline registers of the MIPS pipeline, and presents each stage's control bits to its datapath. It also contains the hazard logic:
- load-use stall detection;
- branch-taken flush;
- EX-stage operand forwarding selects.

It sits between the ID-stage control decoder and the EX/MEM/WB datapath stages.

## Interface
Parameters:
- RAW = 5: register-number width.

Ports:
- clk  in  1  pipeline clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-high; clears all stage registers.
- id_valid  in  1  ID holds a real instruction; 0 = inject bubble.
- id_wb  in  2  [0] reg_write, [1] mem_to_reg.
- id_m  in  3  [0] branch, [1] mem_read, [2] mem_write.
- id_exe  in  6  [0] reg_dst, [1] alu_src, [5:2] alu_op.
- id_rs, id_rt, id_rd  in  RAW each  instruction register fields in ID.
- ex_branch_taken  in  1  EX zero-flag result for the instruction now in EX.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_if_id  out  1  squash IF/ID this cycle.
- ex_exe  out  6  control bits of the instruction in EX.
- ex_m  out  3  m bundle of the instruction in EX.
- ex_wb  out  2  wb bundle of the instruction in EX.
- ex_dst  out  RAW  destination of the instruction in EX.
- mem_m  out  3  m bundle of the instruction in MEM.
- mem_wb  out  2  wb bundle of the instruction in MEM.
- mem_dst  out  RAW  destination of the instruction in MEM.
- wb_wb  out  2  wb bundle of the instruction in WB.
- wb_dst  out  RAW  destination of the instruction in WB.
- fwd_a, fwd_b  out  2 each  EX operand select for rs/rt: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.

## Operation
- **ID/EX register:**
  - Captures id_wb, id_m, id_exe, id_rs and id_rt.
  - Captures dst = id_exe[0] ? id_rd : id_rt.
  - Captures a bubble instead when any of these hold: id_valid=0, stall=1, or the flush condition.
- **Bubble:** all control bits 0 and dst 0. Register numbers are also zeroed.
- **EX/MEM register:** copies ex_m, ex_wb and ex_dst unconditionally. It never stalls.
- **MEM/WB register:** copies mem_wb and mem_dst unconditionally.
- **Flush condition:** ex_m[0] & ex_branch_taken.
  - Drives flush_if_id=1 in the same cycle.
  - Makes ID/EX load a bubble at the next edge.
  - ex_branch_taken is ignored when ex_m[0]=0.
- **Load-use stall:** stall = id_valid & ex_m[1] & ex_dst≠0 & (ex_dst==id_rs | ex_dst==id_rt).
  - Lasts exactly one cycle, because the load advances to MEM.
- **Priority:** flush over stall. When both conditions hold, stall=0 and flush_if_id=1.
- **Forwarding:**
  - fwd_a=10 if mem_wb[0] & mem_dst≠0 & mem_dst==ex_rs.
  - Otherwise fwd_a=01 if wb_wb[0] & wb_dst≠0 & wb_dst==ex_rs.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rule against ex_rt.
  - EX/MEM wins over MEM/WB.
- **Register 0:** never forwarded and never causes a stall.

## Timing
- The stage-to-stage latency is one clock per register.
- An instruction presented in ID at edge n appears on the ex_* outputs after edge n, on mem_* after n+1, and on wb_* after n+2.
- stall, flush_if_id, fwd_a and fwd_b are combinational from registered state plus the ID inputs. They are valid in the same cycle.
- **Reset values:**
  - All stage outputs are 0.
  - stall=0, flush_if_id=0, fwd_a=fwd_b=00.
- **Reset mid-operation:** asserting reset mid-pipeline discards all in-flight bundles immediately (asynchronous). The first post-reset edge loads from ID normally.
- **Stall cycle:** EX/MEM and MEM/WB keep advancing, so older instructions drain normally.
- **Back-to-back loads:** each dependent instruction produces its own independent one-cycle stall.

## Configuration
- **CTRL_PIPE_FWD_EN defined:** forwarding logic as described above.
- **CTRL_PIPE_FWD_EN undefined:**
  - fwd_a and fwd_b are tied to 00.
  - stall = id_valid & ((ex_wb[0] & ex_dst≠0 & match(ex_dst)) | (mem_wb[0] & mem_dst≠0 & match(mem_dst))).
  - match(x) means x==id_rs | x==id_rt.
  - The stall is held until no match remains, which takes up to 2 cycles.
  - The register file is write-first, so WB needs no stall.
  - Flush priority is unchanged.

## Structure
- **Package ctrl_pipe_pkg:**
  - Bundle widths.
  - Bit-index constants: WB_REG_WRITE, WB_MEM_TO_REG, M_BRANCH, M_MEM_READ, M_MEM_WRITE, EXE_REG_DST, EXE_ALU_SRC, EXE_ALU_OP_LSB.
  - FWD_REG, FWD_EXMEM, FWD_MEMWB encodings.
  - Bubble constant.
- **Sub-module hazard_fwd_unit:** purely combinational; computes stall, flush_if_id, fwd_a and fwd_b.
- **Top:** ctrl_pipe holds the three pipeline registers.

## Test plan
- **Plain propagation:** R-type with id_wb=01, id_exe[0]=1, rd=3.
  - ex_dst=3 after 1 edge.
  - mem_dst=3 after 2 edges.
  - wb_wb=01, wb_dst=3 after 3 edges.
  - stall never asserts.
- **Load-use:** lw dst rt=5, then add rs=5.
  - stall=1 for exactly one cycle.
  - ex_* shows a bubble (all 0).
  - The add then reaches EX with fwd_a=01.
- **Forward priority:** add to r4, then sub to r4, then or using rs=4. fwd_a=10, not 01.
- **Branch flush:** beq in EX with ex_branch_taken=1 while a load-use condition is also present.
  - flush_if_id=1 and stall=0.
  - Next cycle ex_* = 0.
- **Register 0 and reset:**
  - A producer with dst=0 followed by a consumer with rs=0 gives fwd_a=00 and no stall.
  - Asserting reset mid-stream zeroes all outputs immediately.
- **CTRL_PIPE_FWD_EN undefined:** add r2 then add rs=2.
  - stall=1 for 2 cycles.
  - fwd_a stays 00.
